// File: rtl/alu_drv_pkg.sv
// Shared types for the ALU command driver.
//   drv_state_e : driver FSM states
//   alu_req_t   : one queued ALU operation (mode, cmd, operands, carry, operand-valid code)
//   alu_flags_t : ALU status flags in response order {cout,oflow,g,e,l,err}
//   MUL_CMD_A/B : arithmetic commands that take the longer multiply latency
package alu_drv_pkg;

  localparam int ALU_DW = 8;
  localparam int ALU_CW = 4;

  localparam logic [ALU_CW-1:0] MUL_CMD_A = 4'd9;
  localparam logic [ALU_CW-1:0] MUL_CMD_B = 4'd10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} drv_state_e;

  typedef struct packed {
    logic              mode;
    logic [ALU_CW-1:0] cmd;
    logic [ALU_DW-1:0] opa;
    logic [ALU_DW-1:0] opb;
    logic              cin;
    logic [1:0]        inp_valid;
  } alu_req_t;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic e;
    logic l;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO, DEPTH entries of alu_req_t, first-in first-out.
// Ports: CLK, RST (async active-low), push/wdata, pop/rdata (head), full, empty.
// The caller only pushes when !full and only pops when !empty.
module alu_req_fifo
  import alu_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     push,
  input  alu_req_t wdata,
  input  logic     pop,
  output alu_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  alu_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator side of the ALU operand/result interface. Queues requests, drives
// the ALU operand bus, waits the command-dependent latency, and hands the
// captured result/flags back over a valid/ready response channel.
// Ports: CLK/RST (async active-low); REQ_* request channel; CE/MODE/CMD/OPA/
// OPB/CIN/INP_VALID ALU bus; RES + flags from ALU; RSP_* response channel; BUSY.
// Optional build macro ALU_ERRCNT_EN adds ERR_CNT, a saturating count of
// captured results with ERR set.
//
// state | meaning
// IDLE  | nothing in flight; loads FIFO head onto the bus when one is queued
// ISSUE | operands on bus for first cycle; latency counter loaded
// WAIT  | bus held while ALU computes; capture and pop on terminal count
// RESP  | response held on RSP_* until consumer accepts
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int DW      = ALU_DW,  // tied to the package request struct width
  parameter int CW      = ALU_CW,
  parameter int DEPTH   = 4,
  parameter int LAT_STD = 1,
  parameter int LAT_MUL = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            REQ_MODE,
  input  logic [CW-1:0]   REQ_CMD,
  input  logic [DW-1:0]   REQ_OPA,
  input  logic [DW-1:0]   REQ_OPB,
  input  logic            REQ_CIN,
  input  logic [1:0]      REQ_INP_VALID,
  output logic            CE,
  output logic            MODE,
  output logic [CW-1:0]   CMD,
  output logic [DW-1:0]   OPA,
  output logic [DW-1:0]   OPB,
  output logic            CIN,
  output logic [1:0]      INP_VALID,
  input  logic [2*DW-1:0] RES,
  input  logic            COUT,
  input  logic            OFLOW,
  input  logic            G,
  input  logic            E,
  input  logic            L,
  input  logic            ERR,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [2*DW-1:0] RSP_RES,
  output logic [5:0]      RSP_FLAGS,
`ifdef ALU_ERRCNT_EN
  output logic [15:0]     ERR_CNT,
`endif
  output logic            BUSY
);

  localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  drv_state_e       state;
  logic [CNT_W-1:0] cnt;
  alu_req_t         req_in;
  alu_req_t         head;
  alu_flags_t       flags_in;
  logic             push, pop, fifo_full, fifo_empty, ready_en, is_mul;

  assign req_in.mode      = REQ_MODE;
  assign req_in.cmd       = REQ_CMD;
  assign req_in.opa       = REQ_OPA;
  assign req_in.opb       = REQ_OPB;
  assign req_in.cin       = REQ_CIN;
  assign req_in.inp_valid = REQ_INP_VALID;

  assign flags_in = '{cout: COUT, oflow: OFLOW, g: G, e: E, l: L, err: ERR};

  // ready_en keeps REQ_READY low while in reset and until the first edge after release.
  assign REQ_READY = ready_en & ~fifo_full;
  assign push      = REQ_VALID & REQ_READY;
  // Capture and pop coincide: the entry leaves the FIFO when its result is taken.
  assign pop       = (state == WAIT) && (cnt == '0);
  assign is_mul    = MODE && ((CMD == MUL_CMD_A) || (CMD == MUL_CMD_B));

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (req_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_en  <= 1'b0;
      CE        <= 1'b0;
      MODE      <= 1'b0;
      CMD       <= '0;
      OPA       <= '0;
      OPB       <= '0;
      CIN       <= 1'b0;
      INP_VALID <= '0;
      RSP_VALID <= 1'b0;
      RSP_RES   <= '0;
      RSP_FLAGS <= '0;
      BUSY      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            CE        <= 1'b1;
            MODE      <= head.mode;
            CMD       <= head.cmd;
            OPA       <= head.opa;
            OPB       <= head.opb;
            CIN       <= head.cin;
            INP_VALID <= head.inp_valid;
            BUSY      <= 1'b1;
            state     <= ISSUE;
          end else begin
            CE        <= 1'b0;
            INP_VALID <= '0;
          end
        end
        ISSUE: begin
          cnt   <= is_mul ? CNT_W'(LAT_MUL - 1) : CNT_W'(LAT_STD - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            RSP_RES   <= RES;
            RSP_FLAGS <= flags_in;
            RSP_VALID <= 1'b1;
            INP_VALID <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            CE        <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ERRCNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ERR_CNT <= '0;
    else if (pop && ERR && (ERR_CNT != 16'hFFFF)) ERR_CNT <= ERR_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: cycle-based transaction model plus a behavioural
// ALU that only presents a valid result once the command latency has elapsed.
// Build with ALU_ERRCNT_EN defined to also cover the error counter.
module tb_alu_cmd_driver;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic [1:0] iv;
  } req_s;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0, REQ_MODE = 1'b0, REQ_CIN = 1'b0;
  logic [3:0]  REQ_CMD = '0;
  logic [7:0]  REQ_OPA = '0, REQ_OPB = '0;
  logic [1:0]  REQ_INP_VALID = '0;
  logic        REQ_READY, CE, MODE, CIN, RSP_VALID, BUSY;
  logic [3:0]  CMD;
  logic [7:0]  OPA, OPB;
  logic [1:0]  INP_VALID;
  logic [15:0] RES = '0;
  logic        COUT = 0, OFLOW = 0, G = 0, E = 0, L = 0, ERR = 0;
  logic        RSP_READY = 1'b1;
  logic [15:0] RSP_RES;
  logic [5:0]  RSP_FLAGS;
`ifdef ALU_ERRCNT_EN
  logic [15:0] ERR_CNT;
`endif

  alu_cmd_driver dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_MODE(REQ_MODE), .REQ_CMD(REQ_CMD), .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB),
    .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
    .CE(CE), .MODE(MODE), .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .INP_VALID(INP_VALID),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
`ifdef ALU_ERRCNT_EN
    .ERR_CNT(ERR_CNT),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input req_s r);
    return (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? 2 : 1;
  endfunction

  // Behavioural ALU: {res[15:0], cout, oflow, g, e, l, err}
  function automatic logic [21:0] alu_fn(input req_s r);
    logic [15:0] res;
    logic co, ov;
    res = '0; co = 1'b0; ov = 1'b0;
    if (r.mode) begin
      case (r.cmd)
        4'd0: begin
          res = r.opa + r.opb;
          co  = res[8];
          ov  = (r.opa[7] == r.opb[7]) && (res[7] != r.opa[7]);
        end
        4'd1:    begin res = r.opa - r.opb; co = (r.opa < r.opb); end
        4'd9:    res = r.opa * r.opb;
        4'd10:   res = (r.opa + 16'd1) * (r.opb + 16'd1);
        default: res = r.opa + r.opb + r.cin;
      endcase
    end else begin
      case (r.cmd)
        4'd0:    res = {8'h00, r.opa & r.opb};
        4'd1:    res = {8'h00, r.opa | r.opb};
        default: res = {8'h00, r.opa ^ r.opb};
      endcase
    end
    return {res, co, ov, r.opa > r.opb, r.opa == r.opb, r.opa < r.opb, r.iv != 2'b11};
  endfunction

  // ---------------- transaction model ----------------
  // An op issues on the edge after it is queued and the driver is idle; its
  // result is taken lat+1 edges after issue; it retires on the first edge
  // thereafter with RSP_READY high.
  req_s        mq[$];
  req_s        m_req;
  logic        m_active = 0, m_captured = 0, m_seen = 0;
  logic        m_was_active, m_rdy0;
  int          m_sz0;
  int          m_cyc = 0, m_issue = 0, m_errcnt = 0;
  logic [21:0] m_exp = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      m_active = 0; m_captured = 0; m_seen = 0; m_errcnt = 0;
    end else begin
      m_was_active = m_active;
      m_sz0        = mq.size();
      m_rdy0       = m_seen && (m_sz0 < DEPTH);
      m_cyc++;
      if (m_was_active) begin
        if (m_captured) begin
          if (RSP_READY) begin m_active = 0; m_captured = 0; end
        end else if (m_cyc == m_issue + lat_of(m_req) + 1) begin
          m_captured = 1;
          m_exp = alu_fn(m_req);
          void'(mq.pop_front());
          if (m_exp[0] && m_errcnt < 65535) m_errcnt++;
        end
      end else if (m_sz0 > 0) begin
        m_active = 1;
        m_issue  = m_cyc;
        m_req    = mq[0];
      end
      if (REQ_VALID && m_rdy0)
        mq.push_back('{REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN, REQ_INP_VALID});
      m_seen = 1;
    end
  end

  // ALU side: result valid only from lat cycles after issue until captured.
  always @(negedge CLK) begin
    if (m_active && !m_captured && (m_cyc >= m_issue + lat_of(m_req)))
      {RES, COUT, OFLOW, G, E, L, ERR} = alu_fn('{MODE, CMD, OPA, OPB, CIN, INP_VALID});
    else
      {RES, COUT, OFLOW, G, E, L, ERR} = {16'hBAD0, 6'b010101};
  end

  // Single compare process
  always @(negedge CLK) begin
    if (!RST) begin
      chk("rst_ctl", {REQ_READY, CE, BUSY, RSP_VALID, INP_VALID, MODE, CIN}, '0);
      chk("rst_bus", {CMD, OPA, OPB}, '0);
      chk("rst_rsp", {RSP_RES, RSP_FLAGS}, '0);
    end else begin
      chk("req_ready", REQ_READY, m_seen && (mq.size() < DEPTH));
      chk("ce", CE, m_active);
      chk("busy", BUSY, m_active);
      chk("rsp_valid", RSP_VALID, m_active && m_captured);
      chk("inp_valid", INP_VALID, (m_active && !m_captured) ? m_req.iv : 2'b00);
      if (m_active)
        chk("bus", {MODE, CMD, OPA, OPB, CIN}, {m_req.mode, m_req.cmd, m_req.opa, m_req.opb, m_req.cin});
      if (m_active && m_captured)
        chk("rsp_data", {RSP_RES, RSP_FLAGS}, m_exp);
    end
`ifdef ALU_ERRCNT_EN
    chk("err_cnt", ERR_CNT, RST ? m_errcnt : 0);
`endif
  end

  int n_rsp_dut = 0;
  always @(posedge CLK) if (RST && RSP_VALID && RSP_READY) n_rsp_dut++;

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic set_req(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [1:0] iv);
    REQ_MODE = mode; REQ_CMD = cmd; REQ_OPA = a; REQ_OPB = b; REQ_CIN = cin; REQ_INP_VALID = iv;
  endtask

  task automatic push(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                      input logic [7:0] b, input logic cin, input logic [1:0] iv);
    int k;
    set_req(mode, cmd, a, b, cin, iv);
    REQ_VALID = 1'b1;
    k = 0;
    while (!(m_seen && mq.size() < DEPTH) && k < 50) begin tick(1); k++; end
    if (k >= 50) chk("push_timeout", 1, 0);
    tick(1);
    REQ_VALID = 1'b0;
  endtask

  // Push into an idle driver; report bus one cycle later and cycles from issue to RSP_VALID.
  task automatic run_op(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] iv,
                        output logic [16:0] bus, output int lat);
    push(mode, cmd, a, b, 1'b0, iv);
    tick(1);
    bus = {CE, OPA, OPB};
    lat = 0;
    while (!RSP_VALID && lat < 20) begin tick(1); lat++; end
  endtask

  logic [16:0] bus;
  int          lat, acc, k, seen_v, base;

  initial begin
    // 1: reset with REQ_VALID high
    #1 RST = 1'b0;
    set_req(1'b1, 4'd0, 8'h55, 8'h66, 1'b0, 2'b11);
    REQ_VALID = 1'b1;
    tick(3);
    RST = 1'b1;
    REQ_VALID = 1'b0;
    tick(2);
    chk("ready_after_rst", REQ_READY, 1);
    chk("idle_after_rst", {BUSY, CE}, 2'b00);

    // 2: ADD 0F+01
    run_op(1'b1, 4'd0, 8'h0F, 8'h01, 2'b11, bus, lat);
    chk("add_bus", bus, {1'b1, 8'h0F, 8'h01});
    chk("add_lat", lat, 2);
    chk("add_res", RSP_RES, 16'h0010);
    chk("add_flags", RSP_FLAGS, 6'b001000);
    tick(2);

    // 3: multiply latency vs neighbours
    run_op(1'b1, 4'd9, 8'h03, 8'h05, 2'b11, bus, lat);
    chk("mul9_lat", lat, 3);
    chk("mul9_res", RSP_RES, 16'h000F);
    tick(2);
    run_op(1'b1, 4'd8, 8'h10, 8'h20, 2'b11, bus, lat);
    chk("cmd8_lat", lat, 2);
    tick(2);
    run_op(1'b1, 4'd10, 8'hFF, 8'h01, 2'b11, bus, lat);
    chk("mul10_lat", lat, 3);
    chk("mul10_res", RSP_RES, 16'h0200);
    tick(2);
    run_op(1'b0, 4'd10, 8'hF0, 8'h3C, 2'b11, bus, lat);
    chk("logic10_lat", lat, 2);
    chk("logic10_res", RSP_RES, 16'h00CC);
    tick(2);

    // 4: backpressure
    RSP_READY = 1'b0;
    base = n_rsp_dut;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, (i % 2) ? 4'd9 : 4'd0, 8'(8'h11 * (i + 1)), 8'(i + 2), 1'b0, 2'b11);
      REQ_VALID = 1'b1;
      k = 0;
      while (!REQ_READY && k < 6) begin tick(1); k++; end
      if (REQ_READY) begin tick(1); acc++; REQ_VALID = 1'b0; end
    end
    chk("bp_accepted", acc, 5);
    chk("bp_ready_low", REQ_READY, 0);
    chk("bp_stalled", RSP_VALID, 1);
    RSP_READY = 1'b1;
    k = 0;
    while (!REQ_READY && k < 20) begin tick(1); k++; end
    tick(1);
    REQ_VALID = 1'b0;
    k = 0;
    while ((m_active || mq.size() != 0) && k < 100) begin tick(1); k++; end
    tick(2);
    chk("bp_rsp_count", n_rsp_dut - base, 6);

    // 5: reset during WAIT
    push(1'b1, 4'd9, 8'h07, 8'h07, 1'b0, 2'b11);
    tick(2);
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    seen_v = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (RSP_VALID) seen_v++; end
    chk("rstw_no_rsp", seen_v, 0);
    chk("rstw_busy", BUSY, 0);
    chk("rstw_ready", REQ_READY, 1);

`ifdef ALU_ERRCNT_EN
    // 6: error counter
    push(1'b1, 4'd0, 8'h01, 8'h02, 1'b0, 2'b01);
    push(1'b1, 4'd0, 8'h03, 8'h04, 1'b0, 2'b11);
    push(1'b1, 4'd9, 8'h05, 8'h06, 1'b0, 2'b10);
    push(1'b0, 4'd1, 8'h07, 8'h08, 1'b0, 2'b11);
    push(1'b1, 4'd1, 8'h09, 8'h0A, 1'b1, 2'b00);
    k = 0;
    while ((m_active || mq.size() != 0) && k < 100) begin tick(1); k++; end
    tick(2);
    chk("errcnt_3", ERR_CNT, 16'd3);
    RST = 1'b0;
    tick(1);
    chk("errcnt_rst", ERR_CNT, 16'd0);
    RST = 1'b1;
    tick(2);
`endif

    // back-to-back with RSP_READY high
    for (int i = 0; i < 4; i++) push(1'b1, 4'(i), 8'(8'h80 + i), 8'(8'h7F - i), 1'(i), 2'b11);
    k = 0;
    while ((m_active || mq.size() != 0) && k < 100) begin tick(1); k++; end
    chk("drain", k < 100, 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
